// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - single-outstanding load/store initiator for the data memory
module dm_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                addr_ok;
  logic                drive_en;

  assign addr_ok = ({1'b0, req_addr} < DEPTH_LIM);

  // Reset gates the write strobe and bus drive so a write caught in ISSUE is dropped.
  assign drive_en   = !rst && (state_q == ISSUE) && we_q;
  assign mem_cmd    = drive_en;
  assign data       = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = !rst && ((state_q == RESP) || (state_q == ERR));
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;

  // Next-state and register-update logic for the request sequencer.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          wdata_d = req_wdata;
          if (addr_ok) begin
            // Memory pins only move for addresses that will actually be issued.
            mem_addr_d = req_addr;
            state_d    = ISSUE;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ERR;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The memory's registered read data is on the bus in this cycle.
        resp_rdata_d = data;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       mem_cmd;
  logic [7:0] mem_addr;
  wire  [7:0] data;

  int n_checks = 0;
  int n_errors = 0;

  dm_access_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .data(data)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, drives the bus in the cycle after a read is issued.
  logic [7:0] mem [0:7];
  logic [7:0] rd_q;
  logic       acc_rd_q;
  logic       mem_oe;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'(i);
      rd_q     <= 8'h00;
      acc_rd_q <= 1'b0;
      mem_oe   <= 1'b0;
    end else begin
      if (mem_cmd) mem[mem_addr[2:0]] <= data;
      rd_q     <= mem[mem_addr[2:0]];
      acc_rd_q <= req_valid && req_ready && !req_we && (req_addr < 8'd8);
      mem_oe   <= acc_rd_q;
    end
  end

  assign data = mem_oe ? rd_q : 8'bzzzz_zzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Undriven bus reads as Z (4-state) or 0 (2-state); test data is never 0 when it matters.
  task automatic chk_rel(input string tag);
    chk1(tag, $isunknown(data) || (data == 8'h00), 1'b1);
  endtask

  task automatic present(input logic we, input logic [7:0] a, input logic [7:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    tick();
    // Scramble the core inputs after the handshake to prove they were latched.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~wd;
  endtask

  task automatic do_store(input logic [7:0] a, input logic [7:0] wd);
    present(1'b1, a, wd);
    chk1("st_issue_cmd", mem_cmd, 1'b1);
    chk8("st_issue_addr", mem_addr, a);
    chk8("st_issue_data", data, wd);
    chk1("st_issue_ready", req_ready, 1'b0);
    chk1("st_issue_valid", resp_valid, 1'b0);
    tick();
    chk1("st_resp_valid", resp_valid, 1'b1);
    chk8("st_resp_rdata", resp_rdata, 8'h00);
    chk1("st_resp_err", resp_err, 1'b0);
    chk1("st_resp_cmd", mem_cmd, 1'b0);
    chk_rel("st_resp_bus");
    tick();
    chk1("st_done_valid", resp_valid, 1'b0);
    chk1("st_done_ready", req_ready, 1'b1);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] exp);
    present(1'b0, a, 8'h5A);
    chk1("ld_issue_cmd", mem_cmd, 1'b0);
    chk8("ld_issue_addr", mem_addr, a);
    chk_rel("ld_issue_bus");
    chk1("ld_issue_ready", req_ready, 1'b0);
    chk1("ld_issue_valid", resp_valid, 1'b0);
    tick();
    chk1("ld_wait_valid", resp_valid, 1'b0);
    chk1("ld_wait_cmd", mem_cmd, 1'b0);
    chk8("ld_wait_addr", mem_addr, a);
    tick();
    chk1("ld_resp_valid", resp_valid, 1'b1);
    chk8("ld_resp_rdata", resp_rdata, exp);
    chk1("ld_resp_err", resp_err, 1'b0);
    chk_rel("ld_resp_bus");
    tick();
    chk1("ld_done_valid", resp_valid, 1'b0);
    chk1("ld_done_ready", req_ready, 1'b1);
    chk8("ld_hold_rdata", resp_rdata, exp);
  endtask

  task automatic do_err(input logic we, input logic [7:0] a);
    present(we, a, 8'hC3);
    chk1("err_valid", resp_valid, 1'b1);
    chk1("err_flag", resp_err, 1'b1);
    chk8("err_rdata", resp_rdata, 8'h00);
    chk1("err_cmd", mem_cmd, 1'b0);
    chk_rel("err_bus");
    tick();
    chk1("err_done_valid", resp_valid, 1'b0);
    chk1("err_done_ready", req_ready, 1'b1);
    chk1("err_done_cmd", mem_cmd, 1'b0);
    chk1("err_hold_flag", resp_err, 1'b1);
  endtask

  logic       bp_we   [0:2];
  logic [7:0] bp_addr [0:2];
  logic [7:0] bp_wd   [0:2];
  logic [7:0] bp_exp  [0:2];

  initial begin
    int acc;
    int nresp;
    int busy;
    logic fire;
    logic fire_we;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    tick();
    tick();
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_valid", resp_valid, 1'b0);
    chk1("rst_cmd", mem_cmd, 1'b0);
    chk8("rst_addr", mem_addr, 8'h00);
    chk8("rst_rdata", resp_rdata, 8'h00);
    chk1("rst_err", resp_err, 1'b0);
    chk_rel("rst_bus");
    rst = 1'b0;
    tick();

    // Reset while a read sits in WAIT: no response, back to IDLE.
    present(1'b0, 8'h04, 8'h5A);
    tick();
    chk1("rw_wait_ready", req_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk1("rw_valid", resp_valid, 1'b0);
    chk1("rw_ready", req_ready, 1'b1);
    chk1("rw_cmd", mem_cmd, 1'b0);
    rst = 1'b0;
    tick();
    chk1("rw_post_valid", resp_valid, 1'b0);
    chk1("rw_post_ready", req_ready, 1'b1);

    do_store(8'h05, 8'hA5);
    do_load(8'h05, 8'hA5);

    for (int i = 0; i < 4; i++) do_load(8'(i), 8'(i));

    do_err(1'b0, 8'h08);
    do_err(1'b1, 8'hFF);
    do_load(8'h01, 8'h01);

    // Backpressure: valid held high across three requests.
    bp_we[0] = 1'b1; bp_addr[0] = 8'h02; bp_wd[0] = 8'h77; bp_exp[0] = 8'h00;
    bp_we[1] = 1'b0; bp_addr[1] = 8'h02; bp_wd[1] = 8'h11; bp_exp[1] = 8'h77;
    bp_we[2] = 1'b0; bp_addr[2] = 8'h03; bp_wd[2] = 8'h22; bp_exp[2] = 8'h03;
    acc = 0; nresp = 0; busy = 0;
    req_valid = 1'b1; req_we = bp_we[0]; req_addr = bp_addr[0]; req_wdata = bp_wd[0];
    for (int cyc = 0; cyc < 20; cyc++) begin
      fire    = req_valid && req_ready;
      fire_we = req_we;
      tick();
      if (busy > 0) busy--;
      if (fire) begin
        busy = fire_we ? 2 : 3;
        acc++;
        if (acc < 3) begin
          req_we = bp_we[acc]; req_addr = bp_addr[acc]; req_wdata = bp_wd[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      chk1("bp_ready", req_ready, (busy == 0));
      if (resp_valid) begin
        if (nresp < 3) chk8("bp_rdata", resp_rdata, bp_exp[nresp]);
        nresp++;
      end
    end
    req_valid = 1'b0;
    chk8("bp_accepts", 8'(acc), 8'd3);
    chk8("bp_responses", 8'(nresp), 8'd3);

    do_store(8'h07, 8'hFF);
    do_load(8'h07, 8'hFF);
    do_store(8'h00, 8'h3C);
    do_load(8'h00, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
